// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl
// Read-side consumer for fifo_top. Pops the FIFO whenever it has data and
// there is room downstream. It absorbs the FIFO's one-cycle registered read
// latency and presents words on a valid/ready stream through a 2-entry skid
// buffer. It also counts delivered words. All logic is in the rd_clk domain.

module fifo_pop_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // Skid buffer: two entries, with 1-bit head/tail pointers that wrap 1 -> 0.
    logic [DATA_WIDTH-1:0] skid_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            occ;        // words held in the skid buffer (0..2)
    logic                  inflight;   // a pop was issued last cycle; data arrives now

    logic                  hs;         // downstream handshake this cycle
    logic [2:0]            fill;       // occupancy after this cycle's capture and handshake
    logic                  room;       // another pop cannot overrun the buffer
    logic                  pending;    // words still owed downstream (buffered or in flight)

    // ------------------------------------------------------------------
    // Stream side and occupancy bookkeeping
    // ------------------------------------------------------------------
    assign m_valid = (occ != 2'd0);
    assign m_data  = skid_mem[head];
    assign hs      = m_valid && m_ready;
    assign busy    = (state != IDLE);
    assign pending = (occ != 2'd0) || inflight;

    // occ + inflight - hs never underflows, because hs needs occ != 0.
    // The same sum is the next occupancy, since an in-flight word is always
    // captured and a handshake always removes one word.
    assign fill = {1'b0, occ} + {2'b00, inflight} - {2'b00, hs};
    assign room = (fill < 3'd2);

    // Pop request: gated by enable, FIFO data present and buffer room; forced low in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fifo_pop = 1'b0;
        if (!rd_rst && enable && !fifo_empty && (state != IDLE || enable) && room) begin
            fifo_pop = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: RUN while enabled, DRAIN while delivering leftovers, IDLE when empty-handed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = pending ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (!pending) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Track the pop in flight, the buffer occupancy and the head/tail pointers.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
        end else begin
            inflight <= fifo_pop;
            occ      <= fill[1:0];
            if (inflight) begin
                tail <= ~tail;
            end
            if (hs) begin
                head <= ~head;
            end
        end
    end

    // Capture the FIFO read word one cycle after its pop, into the buffer tail.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        // NOTE: this storage is reset because m_data reads it directly and must show zero out of reset.
        if (rd_rst) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
        end else if (inflight) begin
            skid_mem[tail] <= fifo_data;
        end
    end

    // Delivered-word counter; wraps silently.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            pop_count <= '0;
        end else if (hs) begin
            pop_count <= pop_count + CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------

    // The FIFO is never popped while empty.
    a_no_underflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(fifo_pop && fifo_empty));

    // A full buffer never has a word in flight toward it.
    a_no_overrun: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(occ == 2'd2 && inflight) && occ != 2'd3);

    // An offered word holds steady until it is taken.
    a_hold: assert property (@(posedge rd_clk) disable iff (rd_rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl
// Directed bench for fifo_pop_ctrl. A queue models fifo_top's read port:
// read data is registered and appears the cycle after a pop. Inputs change
// 1 time unit after the rising edge. Outputs are sampled on the falling edge.

module tb_fifo_pop_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          rdclk_tb  = 1'b0;
    logic          rd_rst    = 1'b0;
    logic          enable    = 1'b0;
    logic          m_ready   = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] pop_count;

    // FIFO model and monitors
    logic [7:0]    fifo_q[$];
    logic [7:0]    rx_q[$];
    int            fifo_cnt   = 0;
    int            pops_total = 0;
    int            underflow  = 0;
    bit            pop_seen   = 1'b0;

    int            n_checks   = 0;
    int            n_fail     = 0;

    assign fifo_empty = (fifo_cnt == 0);

    fifo_pop_ctrl #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk     (rdclk_tb),
        .rd_rst     (rd_rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .pop_count  (pop_count)
    );

    always #5 rdclk_tb = ~rdclk_tb;

    // Mid-cycle sampling: record pops and delivered words.
    always @(negedge rdclk_tb) begin
        pop_seen = fifo_pop;
        if (fifo_pop) pops_total++;
        if (m_valid && m_ready) rx_q.push_back(m_data);
    end

    // Registered read port: the word popped last cycle appears just after the edge.
    always @(posedge rdclk_tb) begin
        #1;
        if (pop_seen) begin
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            else underflow++;
        end
        fifo_cnt = fifo_q.size();
        pop_seen = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge rdclk_tb);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        fifo_cnt = fifo_q.size();
    endtask

    task automatic test_reset();
        #3 rd_rst = 1'b1;
        #1;
        n_checks++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_pop: got %0b expected 0", fifo_pop); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (pop_count !== 4'd0) begin n_fail++; $display("FAIL reset_pop_count: got %0d expected 0", pop_count); end
        step();
        step();
        rd_rst = 1'b0;
        @(negedge rdclk_tb);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %0b expected 0", busy); end
        step();
    endtask

    task automatic test_stream();
        logic       exp_pop [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_v   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_d   [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        logic [7:0] words   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        rx_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) load(words[i]);
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge rdclk_tb);
            n_checks++; if (fifo_pop !== exp_pop[i]) begin n_fail++; $display("FAIL stream_pop c%0d: got %0b expected %0b", i, fifo_pop, exp_pop[i]); end
            n_checks++; if (m_valid !== exp_v[i]) begin n_fail++; $display("FAIL stream_valid c%0d: got %0b expected %0b", i, m_valid, exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++; if (m_data !== exp_d[i]) begin n_fail++; $display("FAIL stream_data c%0d: got %0h expected %0h", i, m_data, exp_d[i]); end
            end
            step();
        end
        n_checks++; if (pop_count !== 4'd4) begin n_fail++; $display("FAIL stream_pop_count: got %0d expected 4", pop_count); end
        n_checks++; if (rx_q.size() != 4) begin n_fail++; $display("FAIL stream_rx_size: got %0d expected 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== words[i]) begin n_fail++; $display("FAIL stream_order %0d: got %0h expected %0h", i, rx_q[i], words[i]); end
        end
        enable = 1'b0;
        step();
        @(negedge rdclk_tb);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_idle_busy: got %0b expected 0", busy); end
        step();
    endtask

    task automatic test_backpressure();
        int base;
        rx_q.delete();
        m_ready = 1'b0;
        base = pops_total;
        for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i));
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge rdclk_tb);
            if (i >= 2) begin
                n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %0b expected 1", i, m_valid); end
                n_checks++; if (m_data !== 8'hA0) begin n_fail++; $display("FAIL bp_hold c%0d: got %0h expected a0", i, m_data); end
            end
            step();
        end
        n_checks++; if (pops_total - base != 2) begin n_fail++; $display("FAIL bp_pops_stalled: got %0d expected 2", pops_total - base); end
        m_ready = 1'b1;
        for (int k = 0; k < 40 && !(rx_q.size() == 6 && !m_valid); k++) step();
        n_checks++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL bp_rx_size: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL bp_order %0d: got %0h expected %0h", i, rx_q[i], 8'hA0 + 8'(i)); end
        end
        n_checks++; if (pops_total - base != 6) begin n_fail++; $display("FAIL bp_pops_total: got %0d expected 6", pops_total - base); end
        n_checks++; if (pop_count !== 4'd10) begin n_fail++; $display("FAIL bp_pop_count: got %0d expected 10", pop_count); end
    endtask

    task automatic test_empty();
        m_ready = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rdclk_tb);
            n_checks++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL empty_pop c%0d: got %0b expected 0", i, fifo_pop); end
            n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid c%0d: got %0b expected 0", i, m_valid); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy c%0d: got %0b expected 1", i, busy); end
            step();
        end
    endtask

    task automatic test_enable_drop();
        int  base;
        logic exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_v    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rx_q.delete();
        base = pops_total;
        load(8'hB0);
        load(8'hB1);
        load(8'hB2);
        for (int i = 0; i < 5; i++) begin
            @(negedge rdclk_tb);
            n_checks++; if (fifo_pop !== (i == 0)) begin n_fail++; $display("FAIL drop_pop c%0d: got %0b expected %0b", i, fifo_pop, (i == 0)); end
            n_checks++; if (busy !== exp_busy[i]) begin n_fail++; $display("FAIL drop_busy c%0d: got %0b expected %0b", i, busy, exp_busy[i]); end
            n_checks++; if (m_valid !== exp_v[i]) begin n_fail++; $display("FAIL drop_valid c%0d: got %0b expected %0b", i, m_valid, exp_v[i]); end
            if (exp_v[i]) begin
                n_checks++; if (m_data !== 8'hB0) begin n_fail++; $display("FAIL drop_data c%0d: got %0h expected b0", i, m_data); end
            end
            step();
            if (i == 0) enable = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge rdclk_tb);
            n_checks++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL drop_idle_pop c%0d: got %0b expected 0", i, fifo_pop); end
            step();
        end
        n_checks++; if (pops_total - base != 1) begin n_fail++; $display("FAIL drop_pops: got %0d expected 1", pops_total - base); end
        n_checks++; if (fifo_cnt != 2) begin n_fail++; $display("FAIL drop_fifo_left: got %0d expected 2", fifo_cnt); end
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL drop_rx_size: got %0d expected 1", rx_q.size()); end
        n_checks++; if (pop_count !== 4'd11) begin n_fail++; $display("FAIL drop_pop_count: got %0d expected 11", pop_count); end
    endtask

    task automatic test_wrap();
        rd_rst = 1'b1;
        #1;
        n_checks++; if (pop_count !== 4'd0) begin n_fail++; $display("FAIL wrap_reset_count: got %0d expected 0", pop_count); end
        fifo_q.delete();
        fifo_cnt = 0;
        rx_q.delete();
        step();
        rd_rst  = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) load(8'hC0 + 8'(i));
        for (int k = 0; k < 60 && !(rx_q.size() == 17 && !m_valid); k++) step();
        n_checks++; if (rx_q.size() != 17) begin n_fail++; $display("FAIL wrap_rx_size: got %0d expected 17", rx_q.size()); end
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== 8'hC0 + 8'(i)) begin n_fail++; $display("FAIL wrap_order %0d: got %0h expected %0h", i, rx_q[i], 8'hC0 + 8'(i)); end
        end
        n_checks++; if (pop_count !== 4'd1) begin n_fail++; $display("FAIL wrap_pop_count: got %0d expected 1", pop_count); end

        // Reset in the middle of a stream clears the outputs immediately.
        for (int i = 0; i < 5; i++) load(8'h50 + 8'(i));
        for (int k = 0; k < 10 && !m_valid; k++) step();
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_restart_valid: got %0b expected 1", m_valid); end
        @(negedge rdclk_tb);
        #2 rd_rst = 1'b1;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", m_valid); end
        n_checks++; if (fifo_pop !== 1'b0) begin n_fail++; $display("FAIL midrst_pop: got %0b expected 0", fifo_pop); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        n_checks++; if (pop_count !== 4'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", pop_count); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %0h expected 0", m_data); end
        step();
        enable = 1'b0;
        rd_rst = 1'b0;
        step();
        @(negedge rdclk_tb);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_release_busy: got %0b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty();
        test_enable_drop();
        test_wrap();
        n_checks++; if (underflow != 0) begin n_fail++; $display("FAIL underflow_pops: got %0d expected 0", underflow); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
